// File: rtl/decode_queue.sv
// Instruction decode queue: buffers fetched RV32I words with their PCs in a
// small FIFO and presents the head entry fully field-decoded. Immediates are
// sign-extended to XLEN. Decoded outputs are forced to zero while the queue
// is empty.
module decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instr,
   input  logic [XLEN-1:0]            in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [6:0]                 out_opcode,
   output logic [2:0]                 out_funct3,
   output logic [6:0]                 out_funct7,
   output logic [4:0]                 out_rs1,
   output logic [4:0]                 out_rs2,
   output logic [4:0]                 out_rd,
   output logic [XLEN-1:0]            out_i_imm,
   output logic [XLEN-1:0]            out_s_imm,
   output logic [XLEN-1:0]            out_b_imm,
   output logic [XLEN-1:0]            out_u_imm,
   output logic [XLEN-1:0]            out_j_imm,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]     instr_mem_r [DEPTH];
   logic [XLEN-1:0] pc_mem_r    [DEPTH];
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [CW-1:0]   count_r;

   logic            in_ready_s;
   logic            out_valid_s;
   logic            push_s;
   logic            pop_s;
   logic [31:0]     head_instr_s;
   logic [XLEN-1:0] head_pc_s;

   // Sign-extend a 32-bit value to the datapath width.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // True when the opcode is one of the supported RV32I major opcodes.
   function automatic logic is_legal_op(input logic [6:0] op);
      logic ok;
      case (op)
         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
         7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Handshake qualifiers; in_ready is held low while reset is asserted.
   assign in_ready_s  = rst_n && (count_r < DEPTH_C);
   assign out_valid_s = (count_r != {CW{1'b0}});
   assign push_s      = in_valid && in_ready_s && !flush;
   assign pop_s       = out_valid_s && out_ready && !flush;

   // Pointer and occupancy tracking; flush clears the queue next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (flush) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         if (push_s) tail_r <= tail_r + PW'(1);
         if (pop_s)  head_r <= head_r + PW'(1);
         if (push_s && !pop_s)
            count_r <= count_r + CW'(1);
         else if (pop_s && !push_s)
            count_r <= count_r - CW'(1);
         else
            count_r <= count_r;
      end
   end

   // Entry storage: written only on an accepted push, never cleared.
   always_ff @(posedge clk) begin
      if (push_s) begin
         instr_mem_r[tail_r] <= in_instr;
         pc_mem_r[tail_r]    <= in_pc;
      end
   end

   // Head entry selection, masked to zero when the queue is empty.
   always_comb begin
      head_instr_s = 32'h0000_0000;
      head_pc_s    = {XLEN{1'b0}};
      if (out_valid_s) begin
         head_instr_s = instr_mem_r[head_r];
         head_pc_s    = pc_mem_r[head_r];
      end else begin
         head_instr_s = 32'h0000_0000;
         head_pc_s    = {XLEN{1'b0}};
      end
   end

   // Field and immediate decode of the head instruction.
   always_comb begin
      out_opcode  = head_instr_s[6:0];
      out_funct3  = head_instr_s[14:12];
      out_funct7  = head_instr_s[31:25];
      out_rs1     = head_instr_s[19:15];
      out_rs2     = head_instr_s[24:20];
      out_rd      = head_instr_s[11:7];
      out_i_imm   = sext32({{20{head_instr_s[31]}}, head_instr_s[31:20]});
      out_s_imm   = sext32({{20{head_instr_s[31]}}, head_instr_s[31:25], head_instr_s[11:7]});
      out_b_imm   = sext32({{19{head_instr_s[31]}}, head_instr_s[31], head_instr_s[7],
                            head_instr_s[30:25], head_instr_s[11:8], 1'b0});
      out_u_imm   = sext32({head_instr_s[31:12], 12'h000});
      out_j_imm   = sext32({{11{head_instr_s[31]}}, head_instr_s[31], head_instr_s[19:12],
                            head_instr_s[20], head_instr_s[30:21], 1'b0});
      out_illegal = out_valid_s && !is_legal_op(head_instr_s[6:0]);
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign out_pc    = head_pc_s;
   assign count     = count_r;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, decode of several instruction
// formats, full/wrap behaviour, flush priority, illegal-opcode flagging,
// mid-stream reset and a 64-bit datapath instance.
module tb_decode_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [31:0] out_i_imm, out_s_imm, out_b_imm, out_u_imm, out_j_imm;
   logic        out_illegal;
   logic [2:0]  count;

   // 64-bit instance shares stimulus with the 32-bit one
   logic        in_ready64, out_valid64, out_illegal64;
   logic [63:0] out_pc64, out_i_imm64, out_s_imm64, out_b_imm64, out_u_imm64, out_j_imm64;
   logic [6:0]  out_opcode64, out_funct7_64;
   logic [2:0]  out_funct3_64;
   logic [4:0]  out_rs1_64, out_rs2_64, out_rd64;
   logic [2:0]  count64;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decode_queue #(.XLEN(32), .DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_i_imm(out_i_imm), .out_s_imm(out_s_imm), .out_b_imm(out_b_imm),
      .out_u_imm(out_u_imm), .out_j_imm(out_j_imm),
      .out_illegal(out_illegal), .count(count)
   );

   decode_queue #(.XLEN(64), .DEPTH(4)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
      .in_pc({32'h0000_0000, in_pc}),
      .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
      .out_opcode(out_opcode64), .out_funct3(out_funct3_64), .out_funct7(out_funct7_64),
      .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_rd(out_rd64),
      .out_i_imm(out_i_imm64), .out_s_imm(out_s_imm64), .out_b_imm(out_b_imm64),
      .out_u_imm(out_u_imm64), .out_j_imm(out_j_imm64),
      .out_illegal(out_illegal64), .count(count64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
      out_ready = 1'b0;

      // reset state
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_i_imm", 64'(out_i_imm), 64'd0);
      #10 rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);
      chk("rel_count", 64'(count), 64'd0);

      // addi x1,x0,-1
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h0000_0100;
      tick();
      in_valid = 1'b0;
      chk("addi_valid", 64'(out_valid), 64'd1);
      chk("addi_opcode", 64'(out_opcode), 64'h13);
      chk("addi_rd", 64'(out_rd), 64'd1);
      chk("addi_rs1", 64'(out_rs1), 64'd0);
      chk("addi_funct3", 64'(out_funct3), 64'd0);
      chk("addi_i_imm", 64'(out_i_imm), 64'hFFFF_FFFF);
      chk("addi_pc", 64'(out_pc), 64'h100);
      chk("addi_illegal", 64'(out_illegal), 64'd0);
      chk("addi_count", 64'(count), 64'd1);
      chk("x64_i_imm", out_i_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("x64_pc", out_pc64, 64'h100);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("addi_pop_count", 64'(count), 64'd0);
      chk("empty_valid", 64'(out_valid), 64'd0);
      chk("empty_rd_zero", 64'(out_rd), 64'd0);
      chk("empty_pc_zero", 64'(out_pc), 64'd0);

      // lui then beq with concurrent pop
      in_valid = 1'b1; in_instr = 32'h1234_52B7; in_pc = 32'h0000_0104;
      tick();
      chk("lui_u_imm", 64'(out_u_imm), 64'h1234_5000);
      chk("lui_rd", 64'(out_rd), 64'd5);
      chk("x64_lui_u_imm", out_u_imm64, 64'h0000_0000_1234_5000);
      in_instr = 32'hFE00_0EE3; in_pc = 32'h0000_0108; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("beq_count", 64'(count), 64'd1);
      chk("beq_b_imm", 64'(out_b_imm), 64'hFFFF_FFFC);
      chk("beq_funct3", 64'(out_funct3), 64'd0);
      chk("beq_opcode", 64'(out_opcode), 64'h63);
      chk("beq_pc", 64'(out_pc), 64'h108);
      chk("x64_beq_b_imm", out_b_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      out_ready = 1'b0;
      chk("beq_drain_count", 64'(count), 64'd0);

      // fill to full, fifth word refused
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_instr = 32'h0000_0013 | (32'(i + 1) << 7);
         in_pc    = 32'h200 + 32'(4 * i);
         tick();
         if (i == 3) chk("full_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      chk("full_count", 64'(count), 64'd4);
      chk("full_head_pc", 64'(out_pc), 64'h200);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("after_pop_ready", 64'(in_ready), 64'd1);
      chk("after_pop_count", 64'(count), 64'd3);
      // push across pointer wrap
      in_valid = 1'b1; in_instr = 32'h0000_0313; in_pc = 32'h300;
      tick();
      in_valid = 1'b0;
      chk("wrap_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      chk("order_pc1", 64'(out_pc), 64'h204);
      chk("order_rd1", 64'(out_rd), 64'd2);
      tick();
      chk("order_pc2", 64'(out_pc), 64'h208);
      tick();
      chk("order_pc3", 64'(out_pc), 64'h20C);
      tick();
      chk("order_pc4", 64'(out_pc), 64'h300);
      chk("order_rd4", 64'(out_rd), 64'd6);
      tick();
      out_ready = 1'b0;
      chk("order_drain", 64'(count), 64'd0);

      // flush beats simultaneous push and pop
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h400 + 32'(4 * i);
         tick();
      end
      chk("preflush_count", 64'(count), 64'd3);
      flush = 1'b1; in_pc = 32'h4F0; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h500;
      tick();
      in_valid = 1'b0;
      chk("postflush_pc", 64'(out_pc), 64'h500);
      chk("postflush_count", 64'(count), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // illegal opcode zero, then csr
      in_valid = 1'b1; in_instr = 32'h0000_0000; in_pc = 32'h600;
      tick();
      in_valid = 1'b0;
      chk("ill_flag", 64'(out_illegal), 64'd1);
      chk("ill_opcode", 64'(out_opcode), 64'd0);
      chk("ill_i_imm", 64'(out_i_imm), 64'd0);
      chk("ill_j_imm", 64'(out_j_imm), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("ill_pop_count", 64'(count), 64'd0);
      chk("ill_empty_flag", 64'(out_illegal), 64'd0);
      in_valid = 1'b1; in_instr = 32'h0000_0073; in_pc = 32'h604;
      tick();
      in_valid = 1'b0;
      chk("csr_flag", 64'(out_illegal), 64'd0);
      chk("csr_opcode", 64'(out_opcode), 64'h73);
      // store format: sw x2,-8(x1) = 0xFE20AC23
      in_valid = 1'b1; in_instr = 32'hFE20_AC23; in_pc = 32'h608;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("sw_s_imm", 64'(out_s_imm), 64'hFFFF_FFF8);
      chk("sw_rs2", 64'(out_rs2), 64'd2);
      // jal x0,-8 = 0xFF9FF06F
      in_valid = 1'b1; in_instr = 32'hFF9F_F06F; in_pc = 32'h60C;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("jal_j_imm", 64'(out_j_imm), 64'hFFFF_FFF8);
      chk("jal_funct7", 64'(out_funct7), 64'h7F);

      // asynchronous reset mid-stream
      in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h700;
      tick();
      in_valid = 1'b0;
      chk("prerst_count", 64'(count), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_count", 64'(count), 64'd0);
      chk("midrst_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("postrst_ready", 64'(in_ready), 64'd1);
      chk("postrst_valid", 64'(out_valid), 64'd0);
      tick();
      chk("postrst_idle_count", 64'(count), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
